// File: rtl/bus_timer.sv
// bus_timer: memory-mapped prescaled 32-bit timer with compare match and level interrupt.
// Define TIMER_CAPTURE_EN to add the capture_i input-capture unit (CAPT, CAPF, CAP_IRQ_EN).
`timescale 1ns/1ps
module bus_timer #(
   parameter int PRESC_W = 16,
   parameter int CNT_W   = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
`ifdef TIMER_CAPTURE_EN
   input  logic        capture_i,
`endif
   input  logic        enable_i,
   input  logic [3:0]  wstrb_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] addr_prev_i,
   input  logic [31:0] wvalue_i,
   output logic [31:0] rvalue_o,
   output logic        irq_o
);

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_PRESC  = 3'd1;
   localparam logic [2:0] A_COUNT  = 3'd2;
   localparam logic [2:0] A_CMP    = 3'd3;
   localparam logic [2:0] A_STATUS = 3'd4;
   localparam logic [2:0] A_CAPT   = 3'd5;
`ifdef TIMER_CAPTURE_EN
   localparam logic [3:0] CTRL_MASK = 4'b1111;
`else
   localparam logic [3:0] CTRL_MASK = 4'b0111;
`endif

   function automatic logic [31:0] byte_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

   logic [3:0]         ctrl_r;
   logic [PRESC_W-1:0] presc_r;
   logic [PRESC_W-1:0] pcnt_r;
   logic [CNT_W-1:0]   count_r;
   logic [CNT_W-1:0]   cmp_r;
   logic               match_r;

   logic               wr_s;
   logic               rd_s;
   logic [2:0]         sel_s;
   logic [31:0]        wmask_s;
   logic               ctrl_wr_s;
   logic               presc_wr_s;
   logic               count_wr_s;
   logic               cmp_wr_s;
   logic               status_wr_s;
   logic [PRESC_W-1:0] presc_wdata_s;
   logic [CNT_W-1:0]   count_wdata_s;
   logic [CNT_W-1:0]   cmp_wdata_s;
   logic               tick_s;
   logic               hit_s;
   logic               match_set_s;
   logic               match_clr_s;
   logic               capf_s;
   logic [CNT_W-1:0]   capt_s;
   logic [31:0]        rdata_s;
   logic               unused_s;

   assign unused_s = ^{addr_prev_i, addr_i[31:5], addr_i[1:0]};

   // Bus decode, byte-merged write data and counter events.
   always_comb begin
      wr_s          = enable_i & (|wstrb_i);
      rd_s          = enable_i & (wstrb_i == 4'b0000);
      sel_s         = addr_i[4:2];
      wmask_s       = byte_mask(wstrb_i);
      ctrl_wr_s     = wr_s & (sel_s == A_CTRL);
      presc_wr_s    = wr_s & (sel_s == A_PRESC);
      count_wr_s    = wr_s & (sel_s == A_COUNT);
      cmp_wr_s      = wr_s & (sel_s == A_CMP);
      status_wr_s   = wr_s & (sel_s == A_STATUS);
      presc_wdata_s = (wvalue_i[PRESC_W-1:0] & wmask_s[PRESC_W-1:0])
                    | (presc_r & ~wmask_s[PRESC_W-1:0]);
      count_wdata_s = (wvalue_i[CNT_W-1:0] & wmask_s[CNT_W-1:0])
                    | (count_r & ~wmask_s[CNT_W-1:0]);
      cmp_wdata_s   = (wvalue_i[CNT_W-1:0] & wmask_s[CNT_W-1:0])
                    | (cmp_r & ~wmask_s[CNT_W-1:0]);
      tick_s        = ctrl_r[0] & (pcnt_r == presc_r);
      hit_s         = (count_r == cmp_r);
      // A bus write to COUNT suppresses the compare for that cycle.
      match_set_s   = tick_s & ~count_wr_s & hit_s;
      match_clr_s   = status_wr_s & wstrb_i[0] & wvalue_i[0];
   end

   // Register read multiplexer.
   always_comb begin
      rdata_s = 32'h0000_0000;
      case (sel_s)
         A_CTRL:   rdata_s = {28'h000_0000, ctrl_r};
         A_PRESC:  rdata_s = 32'(presc_r);
         A_COUNT:  rdata_s = 32'(count_r);
         A_CMP:    rdata_s = 32'(cmp_r);
         A_STATUS: rdata_s = {30'h0000_0000, capf_s, match_r};
         A_CAPT:   rdata_s = 32'(capt_s);
         default:  rdata_s = 32'h0000_0000;
      endcase
   end

   // Control, prescaler, counter, compare and status state plus registered read data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_r   <= 4'b0000;
         presc_r  <= '0;
         pcnt_r   <= '0;
         count_r  <= '0;
         cmp_r    <= '1;
         match_r  <= 1'b0;
         rvalue_o <= 32'h0000_0000;
      end else begin
         if (ctrl_wr_s && wstrb_i[0]) begin
            ctrl_r <= wvalue_i[3:0] & CTRL_MASK;
         end
         if (presc_wr_s) begin
            presc_r <= presc_wdata_s;
         end
         if (presc_wr_s || !ctrl_r[0] || tick_s) begin
            pcnt_r <= '0;
         end else begin
            pcnt_r <= pcnt_r + 1'b1;
         end
         if (count_wr_s) begin
            count_r <= count_wdata_s;
         end else if (tick_s) begin
            if (hit_s && ctrl_r[1]) begin
               count_r <= '0;
            end else begin
               count_r <= count_r + 1'b1;
            end
         end
         if (cmp_wr_s) begin
            cmp_r <= cmp_wdata_s;
         end
         match_r <= match_set_s | (match_r & ~match_clr_s);
         if (rd_s) begin
            rvalue_o <= rdata_s;
         end
      end
   end

`ifdef TIMER_CAPTURE_EN
   logic             cap_meta_r;
   logic             cap_sync_r;
   logic             cap_prev_r;
   logic             capf_r;
   logic [CNT_W-1:0] capt_r;
   logic             cap_edge_s;
   logic             capf_clr_s;

   assign cap_edge_s = cap_sync_r & ~cap_prev_r;
   assign capf_clr_s = status_wr_s & wstrb_i[0] & wvalue_i[1];

   // Capture pin synchroniser, edge detect and snapshot of COUNT.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cap_meta_r <= 1'b0;
         cap_sync_r <= 1'b0;
         cap_prev_r <= 1'b0;
         capf_r     <= 1'b0;
         capt_r     <= '0;
      end else begin
         cap_meta_r <= capture_i;
         cap_sync_r <= cap_meta_r;
         cap_prev_r <= cap_sync_r;
         capf_r     <= cap_edge_s | (capf_r & ~capf_clr_s);
         if (cap_edge_s) begin
            capt_r <= count_r;
         end
      end
   end

   assign capf_s = capf_r;
   assign capt_s = capt_r;
`else
   assign capf_s = 1'b0;
   assign capt_s = '0;
`endif

   assign irq_o = (match_r & ctrl_r[2]) | (capf_s & ctrl_r[3]);

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: reads push expected data, a monitor pops and compares.
`timescale 1ns/1ps
module tb_bus_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] addr_prev;
   logic [31:0] wvalue;
   logic [31:0] rvalue;
   logic        irq;
   logic        capture;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      logic [31:0] val;
      bit          chk_irq;
      bit          irq;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   bus_timer dut (
      .clk_i       (clk),
      .rst_i       (rst),
`ifdef TIMER_CAPTURE_EN
      .capture_i   (capture),
`endif
      .enable_i    (enable),
      .wstrb_i     (wstrb),
      .addr_i      (addr),
      .addr_prev_i (addr_prev),
      .wvalue_i    (wvalue),
      .rvalue_o    (rvalue),
      .irq_o       (irq)
   );

   // Monitor: every read accepted at a rising edge is checked 1ns later.
   always @(posedge clk) begin
      exp_t e;
      if (!rst && enable && wstrb == 4'b0000) begin
         #1;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_read: got rvalue=%h with no expected entry", rvalue);
         end else begin
            e = exp_q.pop_front();
            if (rvalue !== e.val) begin
               n_bad++;
               $display("FAIL %s: rvalue=%h expected=%h", e.name, rvalue, e.val);
            end
            if (e.chk_irq) begin
               n_cmp++;
               if (irq !== e.irq) begin
                  n_bad++;
                  $display("FAIL %s_irq: irq=%b expected=%b", e.name, irq, e.irq);
               end
            end
         end
      end
   end

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
      addr_prev = addr;
      addr      = {27'd0, a, 2'b00};
      wvalue    = d;
      wstrb     = s;
      enable    = 1'b1;
      @(negedge clk);
      enable    = 1'b0;
      wstrb     = 4'b0000;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] v, input string nm,
                     input bit ci, input bit iv);
      exp_t e;
      e.name    = nm;
      e.val     = v;
      e.chk_irq = ci;
      e.irq     = iv;
      exp_q.push_back(e);
      addr_prev = addr;
      addr      = {27'd0, a, 2'b00};
      wstrb     = 4'b0000;
      enable    = 1'b1;
      @(negedge clk);
      enable    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", nm, act, expv);
      end
   endtask

`ifdef TIMER_CAPTURE_EN
   localparam logic [31:0] CTRL_ALL = 32'h0000_000F;
`else
   localparam logic [31:0] CTRL_ALL = 32'h0000_0007;
`endif

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      wstrb     = 4'b0000;
      addr      = 32'h0;
      addr_prev = 32'h0;
      wvalue    = 32'h0;
      capture   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset mid-count with the interrupt asserted
      wr(3'd3, 32'd2, 4'hF);
      wr(3'd0, 32'd5, 4'hF);
      idle(4);
      rd(3'd3, 32'd2, "t1_cmp_before_reset", 1'b1, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("t1_rvalue_async_reset", rvalue, 32'h0);
      chk("t1_irq_async_reset", {31'd0, irq}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rd(3'd3, 32'hFFFF_FFFF, "t1_cmp_reset", 1'b1, 1'b0);
      rd(3'd0, 32'h0, "t1_ctrl_reset", 1'b0, 1'b0);
      rd(3'd1, 32'h0, "t1_presc_reset", 1'b0, 1'b0);
      rd(3'd2, 32'h0, "t1_count_reset", 1'b0, 1'b0);
      rd(3'd4, 32'h0, "t1_status_reset", 1'b0, 1'b0);
      rd(3'd5, 32'h0, "t1_capt_reset", 1'b0, 1'b0);
      rd(3'd7, 32'h0, "t1_reg7_raz", 1'b0, 1'b0);

      // Prescaler: PRESC=3 gives one tick per 4 enabled cycles
      wr(3'd2, 32'd0, 4'hF);
      wr(3'd1, 32'd3, 4'hF);
      wr(3'd0, 32'd1, 4'hF);
      idle(20);
      rd(3'd2, 32'd5, "t2_count_presc3", 1'b0, 1'b0);
      wr(3'd0, 32'd0, 4'hF);
      idle(10);
      rd(3'd2, 32'd5, "t2_count_hold_en0", 1'b0, 1'b0);

      // Compare match, auto-reload, interrupt, W1C and set-beats-clear
      wr(3'd1, 32'd0, 4'hF);
      wr(3'd2, 32'd0, 4'hF);
      wr(3'd3, 32'd10, 4'hF);
      wr(3'd0, 32'd7, 4'hF);
      idle(9);
      rd(3'd2, 32'd9, "t3_count_pre_match", 1'b1, 1'b0);
      rd(3'd4, 32'd0, "t3_status_match_edge", 1'b1, 1'b1);
      rd(3'd2, 32'd0, "t3_count_reloaded", 1'b0, 1'b0);
      rd(3'd4, 32'd1, "t3_status_match", 1'b1, 1'b1);
      wr(3'd4, 32'd1, 4'hF);
      rd(3'd4, 32'd0, "t3_status_w1c", 1'b1, 1'b0);
      idle(6);
      wr(3'd4, 32'd1, 4'hF);
      rd(3'd4, 32'd1, "t3_set_beats_clear", 1'b1, 1'b1);
      wr(3'd0, 32'd0, 4'hF);
      wr(3'd4, 32'd1, 4'hF);
      rd(3'd4, 32'd0, "t3_status_cleared", 1'b1, 1'b0);

      // Silent wrap at the top of the counter range
      wr(3'd2, 32'hFFFF_FFFE, 4'hF);
      wr(3'd3, 32'd5, 4'hF);
      wr(3'd0, 32'd1, 4'hF);
      idle(1);
      rd(3'd2, 32'hFFFF_FFFF, "t4_count_max", 1'b0, 1'b0);
      rd(3'd2, 32'h0, "t4_count_wrap0", 1'b0, 1'b0);
      rd(3'd2, 32'h1, "t4_count_wrap1", 1'b0, 1'b0);
      rd(3'd4, 32'h0, "t4_no_match_on_wrap", 1'b0, 1'b0);
      wr(3'd0, 32'd0, 4'hF);

      // Byte strobes, RAZ/WI fields and write-beats-tick
      wr(3'd3, 32'hFFFF_FFFF, 4'hF);
      wr(3'd3, 32'h0000_AB00, 4'b0010);
      rd(3'd3, 32'hFFFF_ABFF, "t5_cmp_byte1", 1'b0, 1'b0);
      wr(3'd0, 32'hFFFF_FFFF, 4'hF);
      rd(3'd0, CTRL_ALL, "t5_ctrl_raz", 1'b0, 1'b0);
      wr(3'd0, 32'd0, 4'hF);
      wr(3'd1, 32'hFFFF_FFFF, 4'hF);
      rd(3'd1, 32'h0000_FFFF, "t5_presc_width", 1'b0, 1'b0);
      wr(3'd1, 32'd0, 4'hF);
      wr(3'd6, 32'hDEAD_BEEF, 4'hF);
      rd(3'd6, 32'h0, "t5_reg6_raz", 1'b0, 1'b0);
      wr(3'd0, 32'd1, 4'hF);
      idle(2);
      wr(3'd2, 32'h0000_1234, 4'hF);
      rd(3'd2, 32'h0000_1234, "t5_write_beats_tick", 1'b0, 1'b0);
      rd(3'd2, 32'h0000_1235, "t5_count_after_write", 1'b0, 1'b0);
      wr(3'd0, 32'd0, 4'hF);

`ifdef TIMER_CAPTURE_EN
      // Input capture through the synchroniser
      wr(3'd0, 32'd1, 4'hF);
      wr(3'd2, 32'd100, 4'hF);
      capture = 1'b1;
      idle(3);
      capture = 1'b0;
      idle(3);
      wr(3'd0, 32'd0, 4'hF);
      rd(3'd5, 32'd102, "t6_capt", 1'b0, 1'b0);
      rd(3'd4, 32'd2, "t6_capf", 1'b1, 1'b0);
      wr(3'd0, 32'd8, 4'hF);
      rd(3'd4, 32'd2, "t6_capf_irq", 1'b1, 1'b1);
      wr(3'd4, 32'd2, 4'hF);
      rd(3'd4, 32'd0, "t6_capf_w1c", 1'b1, 1'b0);
`endif

      idle(4);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d expected reads never observed", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
